// File: rtl/laser_pkg.sv
// laser_pkg: shared lane state, line levels and vote-phase helper for the laser receiver.
package laser_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} lane_state_e;
  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;
  // Three samples straddling the bit centre feed the 2-of-3 vote.
  function automatic logic is_vote_phase(input int phase, input int os);
    return (phase >= os / 2 - 1) && (phase <= os / 2 + 1);
  endfunction
endpackage

// File: rtl/laser_rx_multi_if.sv
// laser_rx_multi_if: aligned-word valid/ready bus plus per-lane error pulses.
interface laser_rx_multi_if #(
  parameter int CHANNELS  = 2,
  parameter int DATA_BITS = 8
);
  logic [CHANNELS*DATA_BITS-1:0] out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [CHANNELS-1:0]           frame_err;
  logic [CHANNELS-1:0]           overrun;
  logic                          skew_err;
  modport master (output out_data, out_valid, frame_err, overrun, skew_err, input out_ready);
  modport slave  (input out_data, out_valid, frame_err, overrun, skew_err, output out_ready);
endinterface

// File: rtl/laser_rx_lane.sv
// laser_rx_lane: synchronised, oversampled, majority-voted frame decoder with one holding register.
module laser_rx_lane
  import laser_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 laser_in,
  input  logic                 clear,
  output logic                 good,
  output logic                 full,
  output logic [DATA_BITS-1:0] hold,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  lane_state_e state_q, state_d;
  logic sync1_q, sync2_q, prev_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] votes_q, votes_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
  logic full_q, full_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rise, commit, bit_val, load;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rise ? START : IDLE;
      START:   if (commit) state_d = (bit_val == START_LEVEL) ? DATA : IDLE;
      DATA:    if (commit && bit_cnt_q == LAST_BIT) state_d = STOP;
      STOP:    if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rise        = sync2_q == START_LEVEL && prev_q == IDLE_LEVEL;
    commit      = state_q != IDLE && phase_q == LAST_PHASE;
    votes_d     = is_vote_phase(int'(phase_q), OVERSAMPLE) ? {votes_q[1:0], sync2_q} : votes_q;
    bit_val     = (votes_d[0] & votes_d[1]) | (votes_d[0] & votes_d[2]) | (votes_d[1] & votes_d[2]);
    phase_d     = state_q == IDLE ? (rise ? PW'(1) : '0) : (phase_q == LAST_PHASE ? '0 : phase_q + 1'b1);
    bit_cnt_d   = state_q == IDLE ? '0 : (state_q == DATA && commit ? bit_cnt_q + 1'b1 : bit_cnt_q);
    shift_d     = state_q == DATA && commit ? {bit_val, shift_q[DATA_BITS-1:1]} : shift_q;
    good        = state_q == STOP && commit && bit_val == IDLE_LEVEL;
    // A same-cycle clear from the aligner frees the register before this byte lands.
    load        = good && (!full_q || clear);
    full_d      = load || (full_q && !clear);
    hold_d      = load ? shift_q : hold_q;
    frame_err_d = state_q == STOP && commit && bit_val != IDLE_LEVEL;
    overrun_d   = good && !load;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync1_q     <= IDLE_LEVEL;
      sync2_q     <= IDLE_LEVEL;
      prev_q      <= IDLE_LEVEL;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      votes_q     <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= laser_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      votes_q     <= votes_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  assign full      = full_q;
  assign hold      = hold_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: rtl/laser_rx_multi.sv
// laser_rx_multi: per-lane laser decoders feeding a cross-lane word aligner with skew timeout.
module laser_rx_multi
  import laser_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int SKEW_LIMIT = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] laser_in,
  laser_rx_multi_if.master    rx
);
  localparam int SKEW_CYC = SKEW_LIMIT * OVERSAMPLE;
  localparam int TW = $clog2(SKEW_CYC + 1);
  localparam logic [TW-1:0] SKEW_LAST = TW'(SKEW_CYC - 1);
  logic [CHANNELS-1:0] good, full, full_next, frame_err, overrun;
  logic [CHANNELS*DATA_BITS-1:0] hold;
  logic hs, partial, skew_fire, clear;
  logic out_valid_q, out_valid_d, skew_err_q, skew_err_d;
  logic [TW-1:0] timer_q, timer_d;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    laser_rx_lane #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) u_lane (
      .clock     (clock),
      .reset_n   (reset_n),
      .laser_in  (laser_in[c]),
      .clear     (clear),
      .good      (good[c]),
      .full      (full[c]),
      .hold      (hold[c*DATA_BITS +: DATA_BITS]),
      .frame_err (frame_err[c]),
      .overrun   (overrun[c])
    );
  end
  always_comb begin
    hs          = out_valid_q && rx.out_ready;
    partial     = |full && !(&full);
    // A last lane landing on the expiry cycle completes the word instead of timing out.
    skew_fire   = CHANNELS > 1 && partial && timer_q == SKEW_LAST && !(&(full | good));
    clear       = hs || skew_fire;
    full_next   = clear ? good : (full | good);
    out_valid_d = hs ? &full_next : &full;
    timer_d     = partial && !clear ? timer_q + 1'b1 : '0;
    skew_err_d  = skew_fire;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      skew_err_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      skew_err_q  <= skew_err_d;
      timer_q     <= timer_d;
    end
  assign rx.out_data  = hold;
  assign rx.out_valid = out_valid_q;
  assign rx.frame_err = frame_err;
  assign rx.overrun   = overrun;
  assign rx.skew_err  = skew_err_q;
endmodule

// File: tb/tb_laser_rx_multi.sv
// tb_laser_rx_multi: directed and random frames against a frame-level reference of the receiver.
module tb_laser_rx_multi;
  localparam int CH = 2, DB = 8, OS = 8, SK = 2;
  localparam int L = SK * OS, FR = (DB + 2) * OS, MAXC = 8192;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [CH-1:0] laser_in = '0;
  laser_rx_multi_if #(.CHANNELS(CH), .DATA_BITS(DB)) rx ();
  laser_rx_multi #(.CHANNELS(CH), .DATA_BITS(DB), .OVERSAMPLE(OS), .SKEW_LIMIT(SK)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .laser_in(laser_in),
    .rx      (rx)
  );
  always #5 clock = ~clock;
  bit wave [CH][MAXC];
  bit [1:0] ev [CH][MAXC];
  bit [DB-1:0] evb [CH][MAXC];
  bit m_full [CH];
  bit [DB-1:0] m_hold [CH];
  bit m_valid;
  int since;
  bit [CH-1:0] e_ferr, e_ovr;
  bit e_skew;
  int cyc, n_chk, n_fail, rdy_pct, n, n_skew, n_ferr, n_ovr_all, skew_at;
  bit rdy, rnd_rdy;
  logic [CH*DB-1:0] words[$];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [CH*DB-1:0] m_word();
    logic [CH*DB-1:0] w;
    for (int c = 0; c < CH; c++) w[c*DB +: DB] = m_hold[c];
    return w;
  endfunction
  // A frame whose start bit is first seen by edge t is decoded on edge t+1+FR.
  task automatic send(input int c, input int t, input logic [DB-1:0] d, input bit bad);
    if (t + FR + 4 >= MAXC) begin
      $display("FAIL budget: frame at %0d beyond table", t);
      $fatal(1);
    end
    for (int k = 0; k < OS; k++) begin
      wave[c][t+k] = 1'b1;
      for (int b = 0; b < DB; b++) wave[c][t+OS*(b+1)+k] = d[b];
      wave[c][t+OS*(DB+1)+k] = bad;
    end
    ev[c][t+1+FR]  = bad ? 2'd2 : 2'd1;
    evb[c][t+1+FR] = d;
  endtask
  task automatic model_edge(input int e);
    bit [CH-1:0] g, b, f_old, f_new;
    bit hs, part, skew, clr;
    for (int c = 0; c < CH; c++) begin
      g[c] = ev[c][e] == 2'd1;
      b[c] = ev[c][e] == 2'd2;
      f_old[c] = m_full[c];
    end
    hs   = m_valid && rdy;
    part = f_old != 0 && !(&f_old);
    skew = part && (e - since == L) && !(&(f_old | g));
    clr  = hs || skew;
    for (int c = 0; c < CH; c++) begin
      e_ferr[c] = b[c];
      e_ovr[c]  = 1'b0;
      f_new[c]  = f_old[c] && !clr;
      if (g[c]) begin
        if (f_new[c]) e_ovr[c] = 1'b1;
        else begin
          f_new[c]  = 1'b1;
          m_hold[c] = evb[c][e];
        end
      end
    end
    m_valid = hs ? &f_new : &f_old;
    if (f_new != 0 && !(&f_new) && (!part || clr)) since = e;
    for (int c = 0; c < CH; c++) m_full[c] = f_new[c];
    e_skew = skew;
  endtask
  task automatic step();
    if (cyc + 2 >= MAXC) begin
      $display("FAIL budget: cycle table exhausted at %0d", cyc);
      $fatal(1);
    end
    if (rnd_rdy) rdy = $urandom_range(0, 99) < rdy_pct;
    rx.out_ready = rdy;
    for (int c = 0; c < CH; c++) laser_in[c] = wave[c][cyc+1];
    if (rx.out_valid && rdy) words.push_back(rx.out_data);
    @(posedge clock);
    cyc++;
    if (reset_n) model_edge(cyc);
    #1;
    check("out_valid", rx.out_valid, m_valid);
    check("frame_err", rx.frame_err, e_ferr);
    check("overrun", rx.overrun, e_ovr);
    check("skew_err", rx.skew_err, e_skew);
    if (m_valid) check("out_data", rx.out_data, m_word());
    if (rx.skew_err === 1'b1) begin
      n_skew++;
      skew_at = cyc;
    end
    if (rx.frame_err[0] === 1'b1) n_ferr++;
    if (rx.overrun === '1) n_ovr_all++;
  endtask
  task automatic run(input int k);
    repeat (k) step();
  endtask
  task automatic clr_obs();
    words.delete();
    n_skew = 0;
    n_ferr = 0;
    n_ovr_all = 0;
    skew_at = -1;
  endtask
  task automatic do_reset();
    for (int c = 0; c < CH; c++)
      for (int t = cyc + 1; t < MAXC; t++) begin
        wave[c][t] = 1'b0;
        ev[c][t] = 2'd0;
      end
    reset_n = 1'b0;
    m_valid = 1'b0;
    e_ferr = '0;
    e_ovr = '0;
    e_skew = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_full[c] = 1'b0;
      m_hold[c] = '0;
    end
    #1;
    check("rst_valid", rx.out_valid, 1'b0);
    check("rst_data", rx.out_data, '0);
    check("rst_errs", {rx.frame_err, rx.overrun, rx.skew_err}, '0);
    run(2);
    reset_n = 1'b1;
  endtask
  function automatic logic [CH*DB-1:0] first_word();
    return words.size() > 0 ? words[0] : 'x;
  endfunction
  initial begin
    rdy = 1'b1;
    rnd_rdy = 1'b0;
    #2;
    do_reset();
    run(4);
    clr_obs();
    n = cyc + 4;
    send(0, n, 8'hA5, 1'b0);
    send(1, n, 8'h3C, 1'b0);
    run(FR + 20);
    check("aligned_count", words.size(), 1);
    check("aligned_word", first_word(), 16'h3CA5);
    check("aligned_errs", n_skew + n_ferr + n_ovr_all, 0);
    clr_obs();
    n = cyc + 4;
    send(0, n, 8'h11, 1'b0);
    send(1, n + OS, 8'h22, 1'b0);
    run(FR + OS + 20);
    check("skewed_word", first_word(), 16'h2211);
    check("skewed_no_err", n_skew, 0);
    clr_obs();
    n = cyc + 4;
    send(0, n, 8'h55, 1'b0);
    run(FR + L + 10);
    check("timeout_count", n_skew, 1);
    check("timeout_cycle", skew_at, n + 1 + FR + L);
    check("timeout_no_word", words.size(), 0);
    n = cyc + 4;
    send(0, n, 8'h66, 1'b0);
    send(1, n, 8'h77, 1'b0);
    run(FR + 20);
    check("after_timeout_word", first_word(), 16'h7766);
    clr_obs();
    n = cyc + 4;
    send(0, n, 8'hFF, 1'b1);
    run(FR + 20);
    check("stop_err_count", n_ferr, 1);
    check("stop_err_no_word", words.size(), 0);
    clr_obs();
    rdy = 1'b0;
    n = cyc + 4;
    send(0, n, 8'h01, 1'b0);
    send(1, n, 8'h02, 1'b0);
    send(0, n + FR + OS, 8'h03, 1'b0);
    send(1, n + FR + OS, 8'h04, 1'b0);
    run(2 * FR + OS + 10);
    check("overrun_both", n_ovr_all, 1);
    check("overrun_hold", rx.out_data, 16'h0201);
    check("overrun_valid", rx.out_valid, 1'b1);
    rdy = 1'b1;
    run(10);
    check("overrun_count", words.size(), 1);
    check("overrun_word", first_word(), 16'h0201);
    check("overrun_drained", rx.out_valid, 1'b0);
    clr_obs();
    n = cyc + 4;
    wave[0][n] = 1'b1;
    wave[0][n+1] = 1'b1;
    run(40);
    check("glitch_quiet", n_ferr + n_skew + n_ovr_all + words.size(), 0);
    n = cyc + 4;
    send(0, n, 8'h77, 1'b0);
    send(1, n, 8'h88, 1'b0);
    run(30);
    do_reset();
    clr_obs();
    n = cyc + 4;
    send(0, n, 8'h5A, 1'b0);
    send(1, n, 8'hC3, 1'b0);
    run(FR + 20);
    check("post_reset_count", words.size(), 1);
    check("post_reset_word", first_word(), 16'hC35A);
    rnd_rdy = 1'b1;
    repeat (36) begin
      rdy_pct = $urandom_range(0, 1) ? 80 : 10;
      n = cyc + 4;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) != 0)
          send(c, n + $urandom_range(0, 3 * OS), 8'($urandom), $urandom_range(0, 7) == 0);
      run(3 * OS + FR + L + 6);
    end
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    run(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
